// File: rtl/fcl_multi_controller.sv
// Multi-config field-config-loader controller: sticky pending mask, one load at a time,
// ack timeout and completion pulse. Define FCL_RR_ARB_EN for round-robin arbitration.
module fcl_multi_controller #(
    parameter int NUM_CFG     = 4,
    parameter int IDX_W       = $clog2(NUM_CFG),
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = $clog2(ACK_TIMEOUT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CFG-1:0] i_cmd_load_cfg,
    input  logic               i_is_simulating,
    input  logic               i_is_loading,
    output logic               o_go,
    output logic [IDX_W-1:0]   o_cfg_idx,
    output logic               o_cfg_valid,
    output logic [NUM_CFG-1:0] o_pending,
    output logic               o_done,
    output logic               o_timeout
);

    typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_END} state_t;

    state_t             state, state_nxt;
    logic [NUM_CFG-1:0] pending, pending_nxt, grant_mask;
    logic [IDX_W-1:0]   cfg_idx, cfg_idx_nxt, sel_idx;
    logic               sel_vld;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic               done_q, done_nxt, timeout_q, timeout_nxt;

    assign cnt_inc = cnt + CNT_W'(1);

`ifdef FCL_RR_ARB_EN
    logic [IDX_W-1:0] last_grant;
    int               rr_k;

    // Scan from farthest to nearest offset so the nearest pending index after last_grant wins.
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        rr_k    = 0;
        for (int i = NUM_CFG; i >= 1; i--) begin
            rr_k = (int'(last_grant) + i) % NUM_CFG;
            if (pending[IDX_W'(rr_k)]) begin
                sel_idx = IDX_W'(rr_k);
                sel_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= '0;
        else if (|grant_mask)
            last_grant <= sel_idx;
    end
`else
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int i = NUM_CFG - 1; i >= 0; i--) begin
            if (pending[IDX_W'(i)]) begin
                sel_idx = IDX_W'(i);
                sel_vld = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nxt   = state;
        cfg_idx_nxt = cfg_idx;
        cnt_nxt     = cnt;
        grant_mask  = '0;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (sel_vld && !i_is_simulating) begin
                    grant_mask[sel_idx] = 1'b1;
                    cfg_idx_nxt         = sel_idx;
                    state_nxt           = START;
                end
            end
            START: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (i_is_loading) begin
                    state_nxt = WAIT_END;
                end else begin
                    cnt_nxt = cnt_inc;
                    // Abandoned loads are not re-queued.
                    if (cnt_inc == CNT_W'(ACK_TIMEOUT - 1)) begin
                        cnt_nxt     = '0;
                        timeout_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            WAIT_END: begin
                if (!i_is_loading) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A command for the index granted this cycle is absorbed by that grant.
    assign pending_nxt = (pending | i_cmd_load_cfg) & ~grant_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            cfg_idx   <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            cfg_idx   <= cfg_idx_nxt;
            cnt       <= cnt_nxt;
            done_q    <= done_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign o_go        = (state == START);
    assign o_cfg_valid = (state != IDLE);
    assign o_cfg_idx   = cfg_idx;
    assign o_pending   = pending;
    assign o_done      = done_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_fcl_multi_controller.sv
// Scoreboard bench for fcl_multi_controller: expected grant indices are queued with the
// commands and popped on each o_go; a small loader model answers the go strobes.
module tb_fcl_multi_controller;

    localparam int NUM_CFG = 4;
    localparam int IDX_W   = 2;

    logic               clk, rst_n;
    logic [NUM_CFG-1:0] cmd;
    logic               is_sim, is_loading;
    logic               go, cfg_valid, done, timeout;
    logic [IDX_W-1:0]   cfg_idx;
    logic [NUM_CFG-1:0] pending;

    int total = 0;
    int bad   = 0;
    int cyc = 0, n_go = 0, n_done = 0, n_to = 0, go_cyc = 0, to_cyc = 0;
    int exp_q[$];
    int ack_en = 1, ack_dly = 2, busy_len = 5;
    int g0, d0, t0, seen;

    fcl_multi_controller #(.NUM_CFG(NUM_CFG), .ACK_TIMEOUT(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_cmd_load_cfg  (cmd),
        .i_is_simulating (is_sim),
        .i_is_loading    (is_loading),
        .o_go            (go),
        .o_cfg_idx       (cfg_idx),
        .o_cfg_valid     (cfg_valid),
        .o_pending       (pending),
        .o_done          (done),
        .o_timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Loader model: raises busy ack_dly cycles after o_go, holds it busy_len cycles.
    initial begin : loader
        is_loading = 1'b0;
        forever begin
            @(negedge clk);
            if (go && ack_en != 0) begin
                repeat (ack_dly - 1) @(negedge clk);
                is_loading = 1'b1;
                repeat (busy_len) @(negedge clk);
                is_loading = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (go) begin
                if (exp_q.size() == 0) chk("unexp_go", 32'(go), 32'd0);
                else                   chk("go_idx", 32'(cfg_idx), exp_q.pop_front());
                n_go++;
                go_cyc = cyc;
            end
            if (done) n_done++;
            if (timeout) begin
                n_to++;
                to_cyc = cyc;
            end
        end
    end

    task automatic pulse_cmd(input logic [NUM_CFG-1:0] m);
        @(negedge clk);
        cmd = m;
        @(negedge clk);
        cmd = '0;
    endtask

    task automatic wait_quiet(input string tag);
        int q = 0;
        for (int i = 0; i < 300 && q < 3; i++) begin
            @(negedge clk);
            if (!cfg_valid && pending == '0 && !is_loading) q++;
            else q = 0;
        end
        chk(tag, 32'(q >= 3), 32'd1);
    endtask

    task automatic wait_loading(input string tag);
        int ok = 0;
        for (int i = 0; i < 30 && ok == 0; i++) begin
            @(negedge clk);
            if (cfg_valid && is_loading) ok = 1;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_go"},      32'(go),        32'd0);
        chk({pfx, "_valid"},   32'(cfg_valid), 32'd0);
        chk({pfx, "_idx"},     32'(cfg_idx),   32'd0);
        chk({pfx, "_pending"}, 32'(pending),   32'd0);
        chk({pfx, "_done"},    32'(done),      32'd0);
        chk({pfx, "_timeout"}, 32'(timeout),   32'd0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst_n  = 1'b0;
        cmd    = '0;
        is_sim = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("rst");

        // Single load of idx 2
        g0 = n_go; d0 = n_done;
        busy_len = 5;
        exp_q.push_back(2);
        pulse_cmd(4'b0100);
        wait_quiet("t1_quiet");
        chk("t1_go_cnt",   32'(n_go - g0),   32'd1);
        chk("t1_done_cnt", 32'(n_done - d0), 32'd1);
        chk("t1_pending",  32'(pending),     32'd0);

        // Held off by simulation, released later
        is_sim = 1'b1;
        g0 = n_go;
        pulse_cmd(4'b0001);
        repeat (4) @(negedge clk);
        chk("t2_pending", 32'(pending),   32'b0001);
        chk("t2_no_go",   32'(n_go - g0), 32'd0);
        chk("t2_valid",   32'(cfg_valid), 32'd0);
        exp_q.push_back(0);
        is_sim = 1'b0;
        seen = 0;
        for (int i = 0; i < 3 && seen == 0; i++) begin
            @(negedge clk);
            if (go) seen = 1;
        end
        chk("t2_go_latency", 32'(seen), 32'd1);
        wait_quiet("t2_quiet");

        // Loader never acknowledges
        ack_en = 0;
        g0 = n_go; d0 = n_done; t0 = n_to;
        exp_q.push_back(1);
        pulse_cmd(4'b0010);
        for (int i = 0; i < 40 && n_to == t0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("t3_to_cnt",  32'(n_to - t0),     32'd1);
        chk("t3_to_lat",  32'(to_cyc - go_cyc), 32'd16);
        chk("t3_no_done", 32'(n_done - d0),   32'd0);
        chk("t3_valid",   32'(cfg_valid),     32'd0);
        chk("t3_pending", 32'(pending),       32'd0);
        ack_en = 1;

        // Three commands in one cycle; last grant so far was idx 1
`ifdef FCL_RR_ARB_EN
        exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
`else
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
`endif
        g0 = n_go; d0 = n_done;
        busy_len = 3;
        pulse_cmd(4'b1011);
        wait_quiet("t4_quiet");
        chk("t4_go_cnt",   32'(n_go - g0),    32'd3);
        chk("t4_done_cnt", 32'(n_done - d0),  32'd3);
        chk("t4_q_empty",  32'(exp_q.size()), 32'd0);

        // Repeated commands for the in-flight index coalesce into one more load
        busy_len = 8;
        g0 = n_go; d0 = n_done;
        exp_q.push_back(2); exp_q.push_back(2);
        pulse_cmd(4'b0100);
        wait_loading("t5_busy");
        pulse_cmd(4'b0100);
        pulse_cmd(4'b0100);
        chk("t5_pending", 32'(pending), 32'b0100);
        wait_quiet("t5_quiet");
        chk("t5_go_cnt",   32'(n_go - g0),    32'd2);
        chk("t5_done_cnt", 32'(n_done - d0),  32'd2);
        chk("t5_q_empty",  32'(exp_q.size()), 32'd0);

        // Async reset in the middle of a load with another command queued
        busy_len = 10;
        g0 = n_go; d0 = n_done; t0 = n_to;
        exp_q.push_back(2);
        pulse_cmd(4'b0100);
        wait_loading("t6_busy");
        pulse_cmd(4'b1000);
        @(negedge clk);
        chk("t6_pending_pre", 32'(pending), 32'b1000);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t6_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_quiet("t6_quiet");
        chk("t6_no_done",  32'(n_done - d0),  32'd0);
        chk("t6_no_to",    32'(n_to - t0),    32'd0);
        chk("t6_go_cnt",   32'(n_go - g0),    32'd1);
        chk("t6_pending",  32'(pending),      32'd0);
        chk("t6_q_empty",  32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
